frame_window: RTL and testbench

Sensor-side producer for the gesture classifier core. Accepts one 16-bit glove sample per handshake, assembles 8-channel frames in a staging buffer, and maintains a 5-frame sliding window (40 samples). When the window is full and a new frame has been committed, it presents the window and pulses the core's frame-advance input. It holds the window stable for a fixed lock interval while the core computes, back-pressuring the sample source as needed.

---
 rtl/glove_pkg.sv | 19 +
 rtl/frame_stager.sv | 58 +++++
 rtl/frame_window.sv | 83 ++++++++
 tb/tb_frame_window.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glove_pkg.sv
`default_nettype none
// ============================================================================
// Package  : glove_pkg
// Desc     : Shared frame geometry and sample/window types for the glove path.
// Revision : 1.0
// ============================================================================
package glove_pkg;

    localparam int NUM_CH      = 8;
    localparam int NUM_FRAMES  = 5;
    localparam int NUM_SAMPLES = NUM_CH * NUM_FRAMES;
    localparam int FRAMES_W    = $clog2(NUM_FRAMES + 1);

    typedef logic signed [15:0] sample_t;
    typedef sample_t [0:NUM_CH-1]      frame_t;
    typedef sample_t [0:NUM_SAMPLES-1] window_t;

endpackage
`default_nettype wire

// File: rtl/frame_stager.sv
`default_nettype none
// ============================================================================
// Module   : frame_stager
// Desc     : Collects NUM_CH samples into a staging frame; holds it until commit.
// Revision : 1.0
// ============================================================================
module frame_stager
    import glove_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_clear,
    input  sample_t i_sample,
    input  logic    i_valid,
    input  logic    i_commit,
    output logic    o_ready,
    output logic    o_pend,
    output frame_t  o_frame
);

    localparam int c_idx_w = $clog2(NUM_CH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CH - 1);

    logic [c_idx_w-1:0] r_idx;
    logic               r_pend;
    frame_t             r_stage;
    logic               w_accept;

    assign w_accept = i_valid && !r_pend;

    // Commit only happens while pending and accept only while not, so they never collide.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_stage <= '0;
        end else begin
            if (i_commit) begin
                r_pend <= 1'b0;
            end
            if (w_accept) begin
                r_stage[r_idx] <= i_sample;
                if (r_idx == c_last_idx) begin
                    r_idx  <= '0;
                    r_pend <= 1'b1;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
        end
    end

    assign o_ready = !r_pend;
    assign o_pend  = r_pend;
    assign o_frame = r_stage;

endmodule
`default_nettype wire

// File: rtl/frame_window.sv
`default_nettype none
// ============================================================================
// Module   : frame_window
// Desc     : Sliding NUM_FRAMES-frame sample window with frame-advance pulse and lock.
// Revision : 1.0
// ============================================================================
module frame_window
    import glove_pkg::*;
#(
    parameter int LOCK_CYCLES = 500
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  sample_t             i_sample,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_clear,
    output window_t             o_data,
    output logic                o_next,
    output logic [FRAMES_W-1:0] o_frames,
    output logic                o_locked
);

    localparam int c_lock_w = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(LOCK_CYCLES);
    localparam logic [FRAMES_W-1:0] c_frames_full = FRAMES_W'(NUM_FRAMES);

    window_t             r_window;
    logic [FRAMES_W-1:0] r_frames;
    logic [c_lock_w-1:0] r_lock;
    logic                r_next;

    logic                w_pend;
    logic                w_commit;
    logic [FRAMES_W-1:0] w_frames_inc;
    frame_t              w_frame;

    frame_stager u_stager (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (i_clear),
        .i_sample (i_sample),
        .i_valid  (i_valid),
        .i_commit (w_commit),
        .o_ready  (o_ready),
        .o_pend   (w_pend),
        .o_frame  (w_frame)
    );

    // A count of 1 means the lock expires at this edge, so a pending frame may
    // commit here; the window is then frozen for exactly LOCK_CYCLES cycles.
    assign w_commit     = w_pend && (r_lock <= c_lock_w'(1));
    assign w_frames_inc = (r_frames == c_frames_full) ? r_frames : r_frames + FRAMES_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_window <= '0;
            r_frames <= '0;
            r_lock   <= '0;
            r_next   <= 1'b0;
        end else begin
            r_next <= 1'b0;
            if (r_lock != '0) begin
                r_lock <= r_lock - c_lock_w'(1);
            end
            if (w_commit) begin
                r_window <= {r_window[NUM_CH:NUM_SAMPLES-1], w_frame};
                r_frames <= w_frames_inc;
                if (w_frames_inc == c_frames_full) begin
                    r_next <= 1'b1;
                    r_lock <= c_lock_load;
                end
            end
        end
    end

    assign o_data   = r_window;
    assign o_next   = r_next;
    assign o_frames = r_frames;
    assign o_locked = (r_lock != '0);

endmodule
`default_nettype wire

// File: tb/tb_frame_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_window
// Desc     : Randomised self-checking bench for frame_window with a timestamp model.
// Revision : 1.0
// ============================================================================
module tb_frame_window;
    import glove_pkg::*;

    localparam int LOCK = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          valid = 1'b0;
    sample_t       sample = '0;
    logic          ready;
    window_t       data;
    logic          next;
    logic [2:0]    frames;
    logic          locked;

    int errors = 0;
    int checks = 0;

    // Reference model: frames as arrays, lock as an expiry timestamp.
    logic [15:0] mwin [NUM_SAMPLES];
    logic [15:0] mq [$];
    logic [15:0] mframe [NUM_CH];
    bit          mpend = 0;
    int          mframes = 0;
    bit          mnext = 0;
    int          lock_end = 0;
    int          ecount = 0;
    int          nxt_seen = 0;

    frame_window #(.LOCK_CYCLES(LOCK)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sample (sample),
        .i_valid  (valid),
        .o_ready  (ready),
        .i_clear  (clear),
        .o_data   (data),
        .o_next   (next),
        .o_frames (frames),
        .o_locked (locked)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic v, input logic [15:0] s, input logic clr, input logic rn);
        bit commit;
        bit acc;
        ecount++;
        if (!rn || clr) begin
            mq.delete();
            mpend = 0;
            for (int i = 0; i < NUM_SAMPLES; i++) mwin[i] = '0;
            mframes  = 0;
            mnext    = 0;
            lock_end = 0;
        end else begin
            commit = mpend && (ecount >= lock_end);
            acc    = v && !mpend;
            mnext  = 0;
            if (commit) begin
                for (int i = 0; i < NUM_SAMPLES - NUM_CH; i++) mwin[i] = mwin[i + NUM_CH];
                for (int c = 0; c < NUM_CH; c++) mwin[NUM_SAMPLES - NUM_CH + c] = mframe[c];
                mpend = 0;
                if (mframes < NUM_FRAMES) mframes++;
                if (mframes == NUM_FRAMES) begin
                    mnext    = 1;
                    lock_end = ecount + LOCK;
                end
            end
            if (acc) begin
                mq.push_back(s);
                if (mq.size() == NUM_CH) begin
                    for (int c = 0; c < NUM_CH; c++) mframe[c] = mq[c];
                    mq.delete();
                    mpend = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] s, input logic clr, input logic rn);
        valid  = v;
        sample = s;
        clear  = clr;
        rst_n  = rn;
        @(posedge clk);
        model_edge(v, s, clr, rn);
        #1;
        if (next === 1'b1) nxt_seen++;
    endtask

    task automatic send(input logic [15:0] s, output bit ok);
        bit acc;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            acc = ready;
            tick(1'b1, s, 1'b0, 1'b1);
            if (acc) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", data[0]); end
        checks++; if (next !== 1'b0) begin errors++; $display("FAIL reset_next got=%b want=0", next); end
        checks++; if (frames !== 3'd0) begin errors++; $display("FAIL reset_frames got=%0d want=0", frames); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", locked); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
    endtask

    task automatic test_stream_and_lock;
        bit ok;
        bit allok = 1;
        bit bad = 0;
        int e0;
        int cnt;
        nxt_seen = 0;
        for (int f = 0; f < NUM_FRAMES; f++)
            for (int c = 0; c < NUM_CH; c++) begin
                send(16'(16'h0100 * f + c), ok);
                allok &= ok;
            end
        checks++; if (!allok) begin errors++; $display("FAIL stream_accept timed out got=0 want=1"); end
        checks++; if (nxt_seen !== 0) begin errors++; $display("FAIL early_next got=%0d want=0", nxt_seen); end
        tick(1'b0, '0, 1'b0, 1'b1);
        e0 = ecount;
        checks++; if (next !== 1'b1) begin errors++; $display("FAIL first_next got=%b want=1", next); end
        checks++; if (frames !== 3'd5) begin errors++; $display("FAIL frames_full got=%0d want=5", frames); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_start got=%b want=1", locked); end
        checks++; if (data[0] !== 16'h0000) begin errors++; $display("FAIL win0 got=%h want=0000", data[0]); end
        checks++; if (data[39] !== 16'h0407) begin errors++; $display("FAIL win39 got=%h want=0407", data[39]); end
        // Frame 5 fills during the lock, then must stall until it expires.
        for (int c = 0; c < NUM_CH; c++) tick(1'b1, 16'(16'h0500 + c), 1'b0, 1'b1);
        cnt = 0;
        while (next !== 1'b1 && cnt < 40) begin
            if (ready !== 1'b0 || data[0] !== 16'h0000 || data[39] !== 16'h0407) bad = 1;
            tick(1'b1, 16'hDEAD, 1'b0, 1'b1);
            cnt++;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_hold got=changed want=ready0_data_stable"); end
        checks++; if (ecount - e0 !== LOCK) begin errors++; $display("FAIL commit_gap got=%0d want=%0d", ecount - e0, LOCK); end
        checks++; if (data[0] !== 16'h0100) begin errors++; $display("FAIL win0_second got=%h want=0100", data[0]); end
        checks++; if (data[39] !== 16'h0507) begin errors++; $display("FAIL win39_second got=%h want=0507", data[39]); end
        checks++; if (nxt_seen !== 2) begin errors++; $display("FAIL next_count got=%0d want=2", nxt_seen); end
    endtask

    task automatic test_stall;
        bit bad = 0;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) tick(1'b1, 16'(16'h0A00 + c), 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 16'h7777, 1'b0, 1'b1);
            if (frames !== 3'd0 || ready !== 1'b1 || data !== '0) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL idle_hold got=changed want=unchanged"); end
        for (int c = 4; c < NUM_CH; c++) tick(1'b1, 16'(16'h0A00 + c), 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (frames !== 3'd1) begin errors++; $display("FAIL stall_commit got=%0d want=1", frames); end
        checks++; if (data[32] !== 16'h0A00 || data[39] !== 16'h0A07) begin
            errors++; $display("FAIL stall_frame got=%h/%h want=0a00/0a07", data[32], data[39]);
        end
    endtask

    task automatic test_clear;
        bit ok;
        bit allok = 1;
        bit bad = 0;
        for (int c = 0; c < NUM_CH; c++) tick(1'b1, 16'($urandom), 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) tick(1'b1, 16'($urandom), 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b1);
        checks++; if (frames !== 3'd0) begin errors++; $display("FAIL clear_frames got=%0d want=0", frames); end
        checks++; if (data !== '0) begin errors++; $display("FAIL clear_data got=%h want=0", data[32]); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clear_ready got=%b want=1", ready); end
        nxt_seen = 0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                send(16'($urandom), ok);
                allok &= ok;
            end
            tick(1'b0, '0, 1'b0, 1'b1);
            checks++; if (frames !== 3'(f + 1)) begin errors++; $display("FAIL refill_frames got=%0d want=%0d", frames, f + 1); end
            checks++; if (nxt_seen !== ((f == NUM_FRAMES - 1) ? 1 : 0)) begin
                errors++; $display("FAIL refill_next f=%0d got=%0d", f, nxt_seen);
            end
        end
        checks++; if (!allok) begin errors++; $display("FAIL refill_accept timed out got=0 want=1"); end
        for (int i = 0; i < NUM_SAMPLES; i++) if (data[i] !== mwin[i]) bad = 1;
        checks++; if (bad) begin errors++; $display("FAIL refill_window got=%h want=%h", data[39], mwin[39]); end
    endtask

    task automatic test_clear_commit;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < NUM_CH; c++) tick(1'b1, 16'(16'h0C00 + c), 1'b0, 1'b1);
        tick(1'b1, 16'h1234, 1'b1, 1'b1);
        checks++; if (frames !== 3'd0) begin errors++; $display("FAIL cc_frames got=%0d want=0", frames); end
        checks++; if (next !== 1'b0) begin errors++; $display("FAIL cc_next got=%b want=0", next); end
        checks++; if (data !== '0) begin errors++; $display("FAIL cc_data got=%h want=0", data[39]); end
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (frames !== 3'd0) begin errors++; $display("FAIL cc_late_commit got=%0d want=0", frames); end
    endtask

    task automatic test_negative;
        bit ok;
        bit allok = 1;
        bit bad = 0;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int f = 0; f < NUM_FRAMES; f++)
            for (int c = 0; c < NUM_CH; c++) begin
                send((f == NUM_FRAMES - 1 && c == NUM_CH - 1) ? 16'hFF80 : 16'($urandom), ok);
                allok &= ok;
            end
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (!allok) begin errors++; $display("FAIL neg_accept timed out got=0 want=1"); end
        checks++; if (data[39] !== 16'hFF80) begin errors++; $display("FAIL neg_sample got=%h want=ff80", data[39]); end
        for (int i = 0; i < NUM_SAMPLES; i++) if (data[i] !== mwin[i]) bad = 1;
        checks++; if (bad) begin errors++; $display("FAIL neg_window got=%h want=%h", data[0], mwin[0]); end
        // Reset while locked.
        tick(1'b0, '0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0 || frames !== 3'd0 || data[39] !== 16'h0000) begin
            errors++; $display("FAIL midlock_reset got=%b/%0d/%h want=0/0/0000", locked, frames, data[39]);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        bit bad;
        for (int k = 0; k < 700; k++) begin
            tick(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 149) != 0));
            checks++; if (ready !== !mpend) begin errors++; $display("FAIL rnd_ready k=%0d got=%b want=%b", k, ready, !mpend); end
            checks++; if (next !== mnext) begin errors++; $display("FAIL rnd_next k=%0d got=%b want=%b", k, next, mnext); end
            checks++; if (frames !== 3'(mframes)) begin errors++; $display("FAIL rnd_frames k=%0d got=%0d want=%0d", k, frames, mframes); end
            checks++; if (locked !== (ecount < lock_end)) begin
                errors++; $display("FAIL rnd_locked k=%0d got=%b want=%b", k, locked, ecount < lock_end);
            end
            bad = 0;
            for (int i = 0; i < NUM_SAMPLES; i++) if (data[i] !== mwin[i]) bad = 1;
            checks++; if (bad) begin errors++; $display("FAIL rnd_window k=%0d got=%h want=%h", k, data[39], mwin[39]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream_and_lock();
        test_stall();
        test_clear();
        test_clear_commit();
        test_negative();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
